// File: rtl/echo_meter_pkg.sv
// rtl/echo_meter_pkg.sv - state encoding and default sizes shared by the echo_meter slice
package echo_meter_pkg;

    localparam int CNT_LEN_DEF     = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/echo_meter_sync_edge.sv
// rtl/echo_meter_sync_edge.sv - async input synchroniser with rise/fall detect
module echo_meter_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/echo_meter.sv
// rtl/echo_meter.sv - measures echo high time in clock cycles with a programmable give-up limit
module echo_meter
    import echo_meter_pkg::*;
#(
    parameter int CNT_LEN     = CNT_LEN_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               echo,
    input  logic [CNT_LEN-1:0] max_cnt,
    output logic               busy,
    output logic               valid,
    output logic [CNT_LEN-1:0] width,
    output logic               timeout
);

    state_t             state, state_n;
    logic [CNT_LEN-1:0] cnt, cnt_n;
    logic [CNT_LEN-1:0] lim, lim_n;
    logic [CNT_LEN-1:0] width_n;
    logic               timeout_n;
    logic               echo_s, rise, fall;

    echo_meter_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (echo),
        .level (echo_s),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lim_n     = lim;
        width_n   = width;
        timeout_n = timeout;
        case (state)
            IDLE: begin
                if (start) begin
                    lim_n = max_cnt;
                    cnt_n = '0;
                    if (max_cnt == '0) begin
                        width_n   = '0;
                        timeout_n = 1'b1;
                        state_n   = DONE;
                    end else begin
                        state_n = WAIT_RISE;
                    end
                end
            end
            WAIT_RISE: begin
                // rise takes priority over an expiring limit on the same cycle
                if (rise) begin
                    cnt_n   = CNT_LEN'(1);
                    state_n = MEASURE;
                end else if (cnt == lim) begin
                    width_n   = '0;
                    timeout_n = 1'b1;
                    state_n   = DONE;
                end else begin
                    cnt_n = cnt + CNT_LEN'(1);
                end
            end
            MEASURE: begin
                if (fall) begin
                    width_n   = cnt;
                    timeout_n = 1'b0;
                    state_n   = DONE;
                end else if (cnt == lim) begin
                    width_n   = lim;
                    timeout_n = 1'b1;
                    state_n   = DONE;
                end else if (echo_s) begin
                    cnt_n = cnt + CNT_LEN'(1);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lim     <= '0;
            width   <= '0;
            timeout <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            lim     <= lim_n;
            width   <= width_n;
            timeout <= timeout_n;
            busy    <= (state_n == WAIT_RISE) || (state_n == MEASURE);
            valid   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_echo_meter.sv
// tb/tb_echo_meter.sv - self-checking bench for echo_meter
module tb_echo_meter;

    localparam int CNT_LEN = 16;
    localparam int SYNC    = 2;

    logic               clk;
    logic               rst;
    logic               start;
    logic               echo;
    logic [CNT_LEN-1:0] max_cnt;
    logic               busy;
    logic               valid;
    logic [CNT_LEN-1:0] width;
    logic               timeout;

    int n_cmp = 0;
    int n_bad = 0;

    echo_meter #(.CNT_LEN(CNT_LEN), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .echo    (echo),
        .max_cnt (max_cnt),
        .busy    (busy),
        .valid   (valid),
        .width   (width),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 waiting for a fresh rise, 2 counting high samples, 3 reporting
    int       m_phase = 0;
    int       m_lim = 0;
    int       m_waited = 0;
    int       m_run = 0;
    logic     m_busy = 1'b0;
    logic     m_valid = 1'b0;
    int       m_width = 0;
    logic     m_to = 1'b0;
    logic [7:0] hist = '0;

    task automatic model_report(input int w, input logic t);
        m_width = w;
        m_to    = t;
        m_valid = 1'b1;
        m_phase = 3;
    endtask

    always @(posedge clk) begin
        logic es, ep;
        es = hist[SYNC-1];
        ep = hist[SYNC];
        if (rst) begin
            m_phase = 0;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_width = 0;
            m_to    = 1'b0;
            hist    = '0;
        end else begin
            hist    = {hist[6:0], echo};
            m_valid = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_lim    = int'(max_cnt);
                    m_waited = 0;
                    if (m_lim == 0) model_report(0, 1'b1);
                    else m_phase = 1;
                end
                1: begin
                    m_waited++;
                    if (es && !ep) begin
                        m_run   = 1;
                        m_phase = 2;
                    end else if (m_waited == m_lim + 1) begin
                        model_report(0, 1'b1);
                    end
                end
                2: begin
                    if (!es && ep) model_report(m_run, 1'b0);
                    else if (m_run == m_lim) model_report(m_lim, 1'b1);
                    else m_run++;
                end
                default: m_phase = 0;
            endcase
            m_busy = (m_phase == 1) || (m_phase == 2);
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({busy, valid, width, timeout} !== {m_busy, m_valid, CNT_LEN'(m_width), m_to}) begin
            n_bad++;
            $display("FAIL cycle_cmp t=%0t: got busy=%b valid=%b width=%0d timeout=%b, expected busy=%b valid=%b width=%0d timeout=%b",
                     $time, busy, valid, width, timeout, m_busy, m_valid, m_width, m_to);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic arm(input int lim);
        @(negedge clk);
        start   = 1'b1;
        max_cnt = CNT_LEN'(lim);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget, output int edges);
        bit found;
        found = 1'b0;
        edges = 0;
        while (!found && edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
            if (valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL %s: got no valid within %0d cycles, expected a valid pulse", name, budget);
        end
    endtask

    task automatic pulse(input int pre, input int high);
        repeat (pre) @(negedge clk);
        echo = 1'b1;
        repeat (high) @(negedge clk);
        echo = 1'b0;
    endtask

    initial begin
        int e;
        rst     = 1'b1;
        start   = 1'b0;
        echo    = 1'b0;
        max_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_width", int'(width), 0);
        check("reset_timeout", int'(timeout), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: normal 10-cycle pulse
        arm(100);
        fork
            pulse(5, 10);
            wait_valid("t1_valid", 200, e);
        join
        check("t1_width", int'(width), 10);
        check("t1_timeout", int'(timeout), 0);
        check("t1_busy", int'(busy), 0);
        repeat (3) @(negedge clk);

        // 2: no echo at all
        arm(50);
        wait_valid("t2_valid", 100, e);
        check("t2_latency", e, 51);
        check("t2_width", int'(width), 0);
        check("t2_timeout", int'(timeout), 1);
        repeat (3) @(negedge clk);

        // 3: pulse longer than the limit, then a normal measurement
        arm(20);
        fork
            pulse(2, 40);
            wait_valid("t3_valid", 100, e);
        join
        check("t3_width", int'(width), 20);
        check("t3_timeout", int'(timeout), 1);
        repeat (5) @(negedge clk);
        arm(100);
        fork
            pulse(2, 6);
            wait_valid("t3b_valid", 100, e);
        join
        check("t3b_width", int'(width), 6);
        check("t3b_timeout", int'(timeout), 0);
        repeat (3) @(negedge clk);

        // 4: echo already high when armed
        echo = 1'b1;
        repeat (4) @(negedge clk);
        arm(100);
        fork
            begin
                repeat (3) @(negedge clk);
                echo = 1'b0;
                pulse(5, 7);
            end
            wait_valid("t4_valid", 100, e);
        join
        check("t4_width", int'(width), 7);
        check("t4_timeout", int'(timeout), 0);
        repeat (3) @(negedge clk);

        // 5: start re-pulsed with a smaller limit mid-measurement
        arm(100);
        fork
            begin
                repeat (3) @(negedge clk);
                echo = 1'b1;
                repeat (6) @(negedge clk);
                start   = 1'b1;
                max_cnt = CNT_LEN'(5);
                @(negedge clk);
                start   = 1'b0;
                repeat (5) @(negedge clk);
                echo = 1'b0;
            end
            wait_valid("t5_valid", 100, e);
        join
        check("t5_width", int'(width), 12);
        check("t5_timeout", int'(timeout), 0);
        repeat (3) @(negedge clk);

        // 6: reset mid-measurement, then a zero-limit start
        arm(100);
        repeat (2) @(negedge clk);
        echo = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_valid", int'(valid), 0);
        check("t6_rst_width", int'(width), 0);
        check("t6_rst_timeout", int'(timeout), 0);
        rst  = 1'b0;
        echo = 1'b0;
        arm(0);
        check("t6_zero_valid", int'(valid), 1);
        check("t6_zero_width", int'(width), 0);
        check("t6_zero_timeout", int'(timeout), 1);
        @(negedge clk);
        check("t6_zero_valid_drop", int'(valid), 0);
        repeat (3) @(negedge clk);

        // 7: lim=1 with rise meeting the limit, then fall meeting the limit
        @(negedge clk);
        start   = 1'b1;
        max_cnt = CNT_LEN'(1);
        echo    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        echo    = 1'b0;
        wait_valid("t7_valid", 20, e);
        check("t7_latency", e, 3);
        check("t7_width", int'(width), 1);
        check("t7_timeout", int'(timeout), 0);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
